minterm_sweep_checker: RTL and testbench

Sequential stimulus-and-check stage that wraps a 4-input combinational logic function.
- Upstream role: it drives x, y, w, z through all 16 minterms in ascending order, with x as the MSB and z as the LSB.
- Downstream role: it samples the function's response and compares it against a 16-bit expected minterm mask.
- It accumulates mismatch results and reports pass/fail. This replaces hand-written per-minterm stimulus lists with a hardware self-check.

---
 rtl/minterm_sweep_checker_pkg.sv | 16 +
 rtl/minterm_sweep_checker_if.sv | 29 ++
 rtl/minterm_sweep_checker_settle_timer.sv | 23 ++
 rtl/minterm_sweep_checker.sv | 126 ++++++++++++
 tb/tb_minterm_sweep_checker.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/minterm_sweep_checker_pkg.sv
// Shared types and sizing for the minterm sweep checker (package minterm_pkg).
package minterm_pkg;

  localparam int unsigned NUM_MINTERMS = 16;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned CNT_W        = 5;
  localparam int unsigned SETTLE_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/minterm_sweep_checker_if.sv
// Bus between the sweep checker (slave) and the logic under test / controller (master).
interface minterm_sweep_checker_if;
  import minterm_pkg::*;

  logic                start;
  logic [15:0]         expected;
  logic                f_in;
  logic                x;
  logic                y;
  logic                w;
  logic                z;
  logic                busy;
  logic                done;
  logic                pass;
  logic [CNT_W-1:0]    err_count;
  logic [15:0]         err_mask;
  logic [IDX_W-1:0]    first_err_idx;

  modport master (
    output start, expected, f_in,
    input  x, y, w, z, busy, done, pass, err_count, err_mask, first_err_idx
  );

  modport slave (
    input  start, expected, f_in,
    output x, y, w, z, busy, done, pass, err_count, err_mask, first_err_idx
  );

endinterface

// File: rtl/minterm_sweep_checker_settle_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (load)               count <= load_val;
    else if (en && count != '0)  count <= count - 1'b1;
  end

  assign expire = (count == '0);

endmodule

// File: rtl/minterm_sweep_checker.sv
// Sweeps x,y,w,z through all 16 minterms and checks f_in against a latched truth table.
// Optional build macro MINTERM_STOP_ON_FIRST_ERR_EN: finish on the first mismatch.
module minterm_sweep_checker
  import minterm_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  minterm_sweep_checker_if.slave bus
);

  localparam bit HAS_SETTLE = (SETTLE_CYCLES > 0);
  // WAIT lasts SETTLE_CYCLES cycles: the timer is loaded with SETTLE_CYCLES-1 and runs to zero.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    HAS_SETTLE ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   m;
  logic [15:0]        expected_q;
  logic [CNT_W-1:0]   err_count;
  logic [15:0]        err_mask;
  logic [IDX_W-1:0]   first_err_idx;
  logic               done_q;
  logic               pass_q;

  logic accept;
  logic mismatch;
  logic last;
  logic stop_early;
  logic timer_load;
  logic timer_expire;

  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign mismatch = (state == SAMPLE) && (bus.f_in != expected_q[m]);
  assign last     = (m == IDX_W'(NUM_MINTERMS - 1));

`ifdef MINTERM_STOP_ON_FIRST_ERR_EN
  assign stop_early = mismatch;
`else
  assign stop_early = 1'b0;
`endif

  settle_timer #(.W(SETTLE_W)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (state == WAIT),
    .load_val (SETTLE_LOAD),
    .expire   (timer_expire)
  );

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          timer_load = 1'b1;
          state_nxt  = HAS_SETTLE ? WAIT : SAMPLE;
        end
      end
      WAIT: begin
        if (timer_expire) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (last || stop_early) begin
          state_nxt = DONE;
        end else begin
          timer_load = 1'b1;
          state_nxt  = HAS_SETTLE ? WAIT : SAMPLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m             <= '0;
      expected_q    <= '0;
      err_count     <= '0;
      err_mask      <= '0;
      first_err_idx <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        expected_q    <= bus.expected;
        m             <= '0;
        err_count     <= '0;
        err_mask      <= '0;
        first_err_idx <= '0;
        done_q        <= 1'b0;
        pass_q        <= 1'b0;
      end else if (state == SAMPLE) begin
        if (mismatch) begin
          err_mask[m] <= 1'b1;
          err_count   <= err_count + 1'b1;
          if (err_count == '0) first_err_idx <= m;
        end
        if (last || stop_early) begin
          done_q <= 1'b1;
          pass_q <= !mismatch && (err_count == '0);
        end else begin
          m <= m + 1'b1;
        end
      end
    end
  end

  assign bus.x             = m[3];
  assign bus.y             = m[2];
  assign bus.w             = m[1];
  assign bus.z             = m[0];
  assign bus.busy          = (state == WAIT) || (state == SAMPLE);
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_count;
  assign bus.err_mask      = err_mask;
  assign bus.first_err_idx = first_err_idx;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed bench: three checker instances (SETTLE_CYCLES 1, 3, 0) driven by small response models.
module tb_minterm_sweep_checker;

  typedef struct packed {
    logic [3:0]  xywz;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [15:0] err_mask;
    logic [3:0]  first;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        start_v [3];
  logic [15:0] exp_v   [3];
  logic [15:0] model_e [3];
  int unsigned mode_v  [3];
  obs_t        obs     [3];

  int unsigned vectors;
  int unsigned miscompares;

  minterm_sweep_checker_if if0 ();
  minterm_sweep_checker_if if1 ();
  minterm_sweep_checker_if if2 ();

  minterm_sweep_checker #(.SETTLE_CYCLES(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if0));
  minterm_sweep_checker #(.SETTLE_CYCLES(3)) u_s3 (.clk(clk), .rst_n(rst_n), .bus(if1));
  minterm_sweep_checker #(.SETTLE_CYCLES(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Response models: 0 = (~x&~y&z)|(w&z), 1 = stuck-at-0, 2 = inverted, 3 = wrong only at minterm 6
  function automatic logic model_f(input int unsigned md, input logic [15:0] e, input logic [3:0] idx);
    logic xx, yy, ww, zz;
    {xx, yy, ww, zz} = idx;
    case (md)
      0:       return (~xx & ~yy & zz) | (ww & zz);
      1:       return 1'b0;
      2:       return ~e[idx];
      3:       return (idx == 4'd6) ? ~e[idx] : e[idx];
      default: return e[idx];
    endcase
  endfunction

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.expected = exp_v[0];
  assign if1.expected = exp_v[1];
  assign if2.expected = exp_v[2];
  assign if0.f_in = model_f(mode_v[0], model_e[0], {if0.x, if0.y, if0.w, if0.z});
  assign if1.f_in = model_f(mode_v[1], model_e[1], {if1.x, if1.y, if1.w, if1.z});
  assign if2.f_in = model_f(mode_v[2], model_e[2], {if2.x, if2.y, if2.w, if2.z});

  assign obs[0] = {if0.x, if0.y, if0.w, if0.z, if0.busy, if0.done, if0.pass,
                   if0.err_count, if0.err_mask, if0.first_err_idx};
  assign obs[1] = {if1.x, if1.y, if1.w, if1.z, if1.busy, if1.done, if1.pass,
                   if1.err_count, if1.err_mask, if1.first_err_idx};
  assign obs[2] = {if2.x, if2.y, if2.w, if2.z, if2.busy, if2.done, if2.pass,
                   if2.err_count, if2.err_mask, if2.first_err_idx};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Launch a sweep on instance sel and check it cycle by cycle against hand-computed results.
  task automatic run(input string name, input int unsigned sel, input logic [15:0] e,
                     input int unsigned md, input int unsigned s, input int unsigned pulse_at,
                     input logic [4:0] x_err, input logic [15:0] x_mask, input logic [3:0] x_first,
                     input logic x_pass, input logic [3:0] x_last);
    int unsigned done_n;
    int unsigned cur;
    obs_t o;
    done_n = (32'(x_last) + 1) * (s + 1);
    @(negedge clk);
    mode_v[sel]  = md;
    model_e[sel] = e;
    exp_v[sel]   = e;
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
    exp_v[sel]   = ~e;
    o = obs[sel];
    check({name, ".e0_xywz"}, 32'(o.xywz), 32'd0);
    check({name, ".e0_busy"}, 32'(o.busy), 32'd1);
    check({name, ".e0_done"}, 32'(o.done), 32'd0);
    check({name, ".e0_err"},  32'(o.err_count), 32'd0);
    for (int unsigned k = 1; k <= done_n + 2; k++) begin
      @(posedge clk);
      #1;
      o = obs[sel];
      cur = k / (s + 1);
      if (cur > 32'(x_last)) cur = 32'(x_last);
      check({name, ".xywz"}, 32'(o.xywz), cur);
      check({name, ".done"}, 32'(o.done), (k >= done_n) ? 32'd1 : 32'd0);
      check({name, ".busy"}, 32'(o.busy), (k < done_n) ? 32'd1 : 32'd0);
      if (k == done_n || k == done_n + 2) begin
        check({name, ".pass"},  32'(o.pass), 32'(x_pass));
        check({name, ".err"},   32'(o.err_count), 32'(x_err));
        check({name, ".mask"},  32'(o.err_mask), 32'(x_mask));
        check({name, ".first"}, 32'(o.first), 32'(x_first));
      end
      start_v[sel] = (pulse_at != 0) && (k + 1 == pulse_at);
    end
    start_v[sel] = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      exp_v[i]   = '0;
      model_e[i] = '0;
      mode_v[i]  = 0;
    end
    #12;
    check("reset_s1", 32'(obs[0]), 32'd0);
    check("reset_s3", 32'(obs[1]), 32'd0);
    check("reset_s0", 32'(obs[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("correct",   0, 16'h888A, 0, 1, 0, 5'd0, 16'h0000, 4'd0, 1'b1, 4'd15);
`ifdef MINTERM_STOP_ON_FIRST_ERR_EN
    run("stuck0",    0, 16'h0001, 1, 1, 0, 5'd1, 16'h0001, 4'd0, 1'b0, 4'd0);
    run("inverted",  0, 16'hA5A5, 2, 1, 0, 5'd1, 16'h0001, 4'd0, 1'b0, 4'd0);
    run("inv_s0",    2, 16'hA5A5, 2, 0, 0, 5'd1, 16'h0001, 4'd0, 1'b0, 4'd0);
    run("single6",   0, 16'h1234, 3, 1, 0, 5'd1, 16'h0040, 4'd6, 1'b0, 4'd6);
`else
    run("stuck0",    0, 16'h0001, 1, 1, 0, 5'd1, 16'h0001, 4'd0, 1'b0, 4'd15);
    run("inverted",  0, 16'hA5A5, 2, 1, 0, 5'h10, 16'hFFFF, 4'd0, 1'b0, 4'd15);
    run("inv_s0",    2, 16'hA5A5, 2, 0, 0, 5'h10, 16'hFFFF, 4'd0, 1'b0, 4'd15);
    run("single6",   0, 16'h1234, 3, 1, 0, 5'd1, 16'h0040, 4'd6, 1'b0, 4'd15);
`endif
    run("settle3",   1, 16'h888A, 0, 3, 0, 5'd0, 16'h0000, 4'd0, 1'b1, 4'd15);
    run("settle0",   2, 16'h888A, 0, 0, 0, 5'd0, 16'h0000, 4'd0, 1'b1, 4'd15);
    run("mid_start", 0, 16'h888A, 0, 1, 10, 5'd0, 16'h0000, 4'd0, 1'b1, 4'd15);

    // Restart from DONE clears done/pass on the next edge, then reset lands mid-sweep.
    @(negedge clk);
    mode_v[0]  = 2;
    model_e[0] = 16'hA5A5;
    exp_v[0]   = 16'hA5A5;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check("restart.done", 32'(obs[0].done), 32'd0);
    check("restart.pass", 32'(obs[0].pass), 32'd0);
    check("restart.busy", 32'(obs[0].busy), 32'd1);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(obs[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 32'(obs[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
